request_encoder8to3: RTL and testbench

REQUEST_ENCODER8TO3 -- requirements
Module: request_encoder8to3

---
 rtl/request_encoder_pkg.sv | 16 +
 rtl/prio_pick8.sv | 25 ++
 rtl/request_encoder8to3.sv | 92 +++++++++
 tb/tb_request_encoder8to3.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/request_encoder_pkg.sv
// Shared widths, code type and one-hot helper for the 8-line request encoder.
// Round-robin priority is selected by defining REQUEST_ENCODER_RR_EN.
package request_encoder_pkg;

  localparam int unsigned REQ_W  = 8;
  localparam int unsigned CODE_W = 3;

  typedef logic [CODE_W-1:0] code_t;

  function automatic logic [REQ_W-1:0] onehot(input code_t c);
    logic [REQ_W-1:0] one;
    one = REQ_W'(1);
    return one << c;
  endfunction

endpackage

// File: rtl/prio_pick8.sv
// Combinational priority picker: lowest set bit at or after start_i, wrapping 7 -> 0.
// Reports index 0 with found_o low when the vector is empty.
module prio_pick8
  import request_encoder_pkg::*;
(
  input  logic [REQ_W-1:0] vec_i,
  input  code_t            start_i,
  output logic             found_o,
  output code_t            idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < int'(REQ_W); i++) begin
      code_t j;
      j = code_t'(start_i + code_t'(i));
      if (!found_o && vec_i[j]) begin
        found_o = 1'b1;
        idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/request_encoder8to3.sv
// Collects multi-hot requests into a pending set and presents them one code at a time
// with valid/ready handshake. Define REQUEST_ENCODER_RR_EN for round-robin priority.
module request_encoder8to3
  import request_encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_W-1:0] req,
  output code_t            code,
  output logic             valid,
  input  logic             ready,
  output logic [REQ_W-1:0] pending
);

  logic [REQ_W-1:0] pending_q, pending_d;
  code_t            code_q, code_d;
  logic             valid_q, valid_d;

  logic             fire;
  logic             load;
  logic [REQ_W-1:0] clr;
  logic [REQ_W-1:0] source;
  logic             pick_found;
  code_t            pick_idx;
  code_t            start;

`ifdef REQUEST_ENCODER_RR_EN
  code_t ptr_q, ptr_d;

  // Search begins just after the line granted this cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (fire) begin
      ptr_d = code_t'(code_q + code_t'(1));
    end
  end

  assign start = ptr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign start = '0;
`endif

  always_comb begin
    fire      = valid_q & ready;
    clr       = fire ? onehot(code_q) : '0;
    // A request arriving on the line being cleared re-arms it.
    pending_d = (pending_q & ~clr) | req;
    source    = pending_q & ~clr;
    load      = !valid_q || fire;
  end

  prio_pick8 u_pick (
    .vec_i   (source),
    .start_i (start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    if (load) begin
      valid_d = pick_found;
      code_d  = pick_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_request_encoder8to3.sv
// Directed vector bench for request_encoder8to3; expectations follow REQUEST_ENCODER_RR_EN.
module tb_request_encoder8to3;

`ifdef REQUEST_ENCODER_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [2:0] code;
  logic       valid;
  logic       ready;
  logic [7:0] pending;

  int n_vec;
  int n_err;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_code;
    logic [7:0] exp_pending;
  } vec_t;

  vec_t vecs[$];

  request_encoder8to3 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .code    (code),
    .valid   (valid),
    .ready   (ready),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic add(input logic r, input logic [7:0] q, input logic rd,
                     input logic ev, input logic [2:0] ec, input logic [7:0] ep);
    vec_t v;
    v.rst_n = r; v.req = q; v.ready = rd;
    v.exp_valid = ev; v.exp_code = ec; v.exp_pending = ep;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] q, input logic rd);
    rst_n = r; req = q; ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ff;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = '0;
    ready = 1'b0;
    ff    = 8'hFF;

    // Reset; req during reset must be ignored
    add(0, 8'hFF, 1, 0, 0, 8'h00);
    add(0, 8'h00, 0, 0, 0, 8'h00);
    // Single request, two edges to valid, then fire; ready while idle is harmless
    add(1, 8'h01, 1, 0, 0, 8'h01);
    add(1, 8'h00, 1, 1, 0, 8'h01);
    add(1, 8'h00, 1, 0, 0, 8'h00);
    add(1, 8'h00, 1, 0, 0, 8'h00);
    // Multi-hot A4 held under back-pressure, then drained in order
    add(1, 8'hA4, 0, 0, 0, 8'hA4);
    for (int i = 0; i < 5; i++) add(1, 8'h00, 0, 1, 3'd2, 8'hA4);
    add(1, 8'h00, 1, 1, 3'd5, 8'hA0);
    add(1, 8'h00, 1, 1, 3'd7, 8'h80);
    add(1, 8'h00, 1, 0, 0, 8'h00);
    // All eight lines drain in eight consecutive fires
    add(1, 8'hFF, 1, 0, 0, 8'hFF);
    for (int i = 0; i < 8; i++) add(1, 8'h00, 1, 1, 3'(i), ff << i);
    add(1, 8'h00, 1, 0, 0, 8'h00);
    // Line 3 re-armed during its own fire
    add(1, 8'h08, 0, 0, 0, 8'h08);
    add(1, 8'h00, 0, 1, 3'd3, 8'h08);
    add(1, 8'h08, 1, 0, 0, 8'h08);
    add(1, 8'h00, 1, 1, 3'd3, 8'h08);
    add(1, 8'h00, 1, 0, 0, 8'h00);
    // Reset mid-operation discards everything
    add(1, 8'h3C, 0, 0, 0, 8'h3C);
    add(1, 8'h00, 0, 1, RrEn ? 3'd4 : 3'd2, 8'h3C);
    add(0, 8'hFF, 1, 0, 0, 8'h00);
    add(1, 8'h00, 0, 0, 0, 8'h00);
    add(1, 8'h00, 0, 0, 0, 8'h00);
    // First load after release
    add(1, 8'h10, 0, 0, 0, 8'h10);
    add(1, 8'h00, 0, 1, 3'd4, 8'h10);
    add(1, 8'h00, 1, 0, 0, 8'h00);
    // Lines 0 and 7 requested every cycle
    add(1, 8'h81, 1, 0, 0, 8'h81);
    for (int i = 0; i < 4; i++)
      add(1, 8'h81, 1, 1, ((i % 2 == 0) != RrEn) ? 3'd0 : 3'd7, 8'h81);
    add(1, 8'h00, 1, 1, RrEn ? 3'd7 : 3'd0, RrEn ? 8'h80 : 8'h01);
    add(1, 8'h00, 1, 0, 0, 8'h00);

    foreach (vecs[k]) begin
      step(vecs[k].rst_n, vecs[k].req, vecs[k].ready);
      check("valid", k, {7'd0, valid}, {7'd0, vecs[k].exp_valid});
      check("pending", k, pending, vecs[k].exp_pending);
      if (vecs[k].exp_valid || !vecs[k].rst_n)
        check("code", k, {5'd0, code}, {5'd0, vecs[k].exp_code});
    end

    // Re-armed line waits behind a pending line, then is presented again
    begin
      int waited;
      step(1, 8'h22, 0);
      waited = 0;
      while (!valid && waited < 5) begin
        step(1, 8'h00, 0);
        waited++;
      end
      check("wait_valid", 100, {7'd0, valid}, 8'h01);
      check("rearm_first", 101, {5'd0, code}, 8'h01);
      step(1, 8'h02, 1);
      check("rearm_next", 102, {5'd0, code}, 8'h05);
      check("rearm_pend", 103, pending, 8'h22);
      step(1, 8'h00, 1);
      check("rearm_again", 104, {5'd0, code}, 8'h01);
      check("rearm_valid", 105, {7'd0, valid}, 8'h01);
      step(1, 8'h00, 1);
      check("rearm_done", 106, {7'd0, valid}, 8'h00);
      check("rearm_empty", 107, pending, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
